stage_if_fetchq: RTL and testbench

- Parametrised instruction-fetch stage with a prefetch queue between the fetch PC and the decode stage.
- Fetches one word per cycle from an external combinational instruction ROM and buffers {PC, Inst} in a DEPTH-entry FIFO.
- Presents the queue head to ID through a valid/ready handshake.
- A redirect from MEM (branch/jump) flushes the queue and restarts fetch at the target.

---
 rtl/if_pkg.sv | 13 +
 rtl/fetchq_fifo.sv | 48 ++++
 rtl/stage_if_fetchq.sv | 77 +++++++
 tb/tb_stage_if_fetchq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the fetch stage and its prefetch queue
package if_pkg;

    localparam int PC_STEP         = 4;
    localparam int INST_ALIGN_BITS = 2;
    localparam int IF_XLEN         = 32;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// rtl/fetchq_fifo.sv - synchronous FIFO with flush, push-at-full-with-pop and occupancy count
module fetchq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !flush && push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/stage_if_fetchq.sv
// rtl/stage_if_fetchq.sv - fetch PC plus prefetch queue feeding ID; STAGE_IF_PERF_EN adds stall/flush counters
module stage_if_fetchq
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       Clk,
    input  logic                       Clrn,
    input  logic                       Redirect,
    input  logic [XLEN-1:0]            Redirect_Target,
    output logic [XLEN-1:0]            Imem_Addr,
    input  logic [XLEN-1:0]            Imem_Inst,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [XLEN-1:0]            Out_PC,
    output logic [XLEN-1:0]            Out_PC4,
    output logic [XLEN-1:0]            Out_Inst,
`ifdef STAGE_IF_PERF_EN
    output logic [31:0]                Perf_Stall,
    output logic [31:0]                Perf_Flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << INST_ALIGN_BITS) - 1);

    logic [XLEN-1:0]   fetch_pc;
    logic [2*XLEN-1:0] head;
    logic              full;
    logic              push;
    logic              pop;

    assign pop       = (Count != '0) & Out_Ready & ~Redirect;
    assign push      = ~Redirect & (~full | pop);
    assign Out_Valid = (Count != '0) & ~Redirect;
    assign Imem_Addr = fetch_pc;
    assign Out_PC    = head[2*XLEN-1:XLEN];
    assign Out_Inst  = head[XLEN-1:0];
    assign Out_PC4   = Out_PC + XLEN'(PC_STEP);

    fetchq_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (Clk),
        .resetn (Clrn),
        .flush  (Redirect),
        .push   (push),
        .pop    (pop),
        .wdata  ({fetch_pc, Imem_Inst}),
        .rdata  (head),
        .count  (Count),
        .full   (full)
    );

    // Without a push the address is held so the same ROM word is re-read.
    always_ff @(posedge Clk) begin
        if (!Clrn)         fetch_pc <= RESET_PC;
        else if (Redirect) fetch_pc <= Redirect_Target & ~ALIGN_MASK;
        else if (push)     fetch_pc <= fetch_pc + XLEN'(PC_STEP);
    end

`ifdef STAGE_IF_PERF_EN
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            Perf_Stall <= '0;
            Perf_Flush <= '0;
        end else begin
            if (full && !pop && Perf_Stall != '1) Perf_Stall <= Perf_Stall + 32'd1;
            if (Redirect && Perf_Flush != '1)     Perf_Flush <= Perf_Flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_if_fetchq.sv
// tb/tb_stage_if_fetchq.sv - scoreboard bench for stage_if_fetchq; honours STAGE_IF_PERF_EN
module tb_stage_if_fetchq;
    import if_pkg::*;

    localparam logic [31:0] ROM_KEY = 32'h5A5A_0000;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Inst;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_PC;
    logic [31:0] Out_PC4;
    logic [31:0] Out_Inst;
    logic [2:0]  Count;
`ifdef STAGE_IF_PERF_EN
    logic [31:0] Perf_Stall;
    logic [31:0] Perf_Flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    fetch_entry_t exp_q[$];

    always #5 Clk = ~Clk;

    assign Imem_Inst = Imem_Addr ^ ROM_KEY;

    stage_if_fetchq #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk             (Clk),
        .Clrn            (Clrn),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .Imem_Addr       (Imem_Addr),
        .Imem_Inst       (Imem_Inst),
        .Out_Valid       (Out_Valid),
        .Out_Ready       (Out_Ready),
        .Out_PC          (Out_PC),
        .Out_PC4         (Out_PC4),
        .Out_Inst        (Out_Inst),
`ifdef STAGE_IF_PERF_EN
        .Perf_Stall      (Perf_Stall),
        .Perf_Flush      (Perf_Flush),
`endif
        .Count           (Count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_from(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            fetch_entry_t e;
            e.pc   = start + 32'(4 * i);
            e.inst = e.pc ^ ROM_KEY;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    always @(negedge Clk) begin
        if (Out_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL head_unexpected: got pc %h required no valid head", Out_PC);
            end else begin
                check("head_pc", Out_PC, exp_q[0].pc);
                check("head_pc4", Out_PC4, exp_q[0].pc + 32'd4);
                check("head_inst", Out_Inst, exp_q[0].inst);
                if (Out_Ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        // Reset while a redirect is also requested: reset must win.
        Clrn            = 1'b0;
        Redirect        = 1'b1;
        Redirect_Target = 32'h0000_0555;
        Out_Ready       = 1'b0;
        step(2);
        check("rst_addr", Imem_Addr, 32'h0);
        check("rst_count", 32'(Count), 32'd0);
        Redirect = 1'b0;
        #1;
        check("rst_valid", 32'(Out_Valid), 32'd0);
`ifdef STAGE_IF_PERF_EN
        check("rst_perf_stall", Perf_Stall, 32'd0);
        check("rst_perf_flush", Perf_Flush, 32'd0);
`endif

        // Streaming with ID always ready.
        expect_from(32'h0);
        Clrn      = 1'b1;
        Out_Ready = 1'b1;
        step(8);
        check("steady_count", 32'(Count), 32'd1);
        check("steady_addr", Imem_Addr, 32'h20);

        // ID stalls: queue fills to DEPTH and the fetch address holds.
        Out_Ready = 1'b0;
        step(10);
        check("full_count", 32'(Count), 32'd4);
        check("full_addr", Imem_Addr, 32'h2C);
        check("full_valid", 32'(Out_Valid), 32'd1);

        // Full queue with ready: push and pop together.
        Out_Ready = 1'b1;
        step(1);
        check("fullpp_count", 32'(Count), 32'd4);
        check("fullpp_addr", Imem_Addr, 32'h30);
        step(5);
        check("fullpp_count2", 32'(Count), 32'd4);
        check("fullpp_addr2", Imem_Addr, 32'h44);

        // Redirect from a full queue, then fill to three entries.
        Out_Ready       = 1'b0;
        Redirect        = 1'b1;
        Redirect_Target = 32'h0000_0050;
        expect_from(32'h50);
        step(1);
        Redirect = 1'b0;
        check("redir1_count", 32'(Count), 32'd0);
        check("redir1_addr", Imem_Addr, 32'h50);
`ifdef STAGE_IF_PERF_EN
        check("perf_flush_one", Perf_Flush, 32'd1);
`endif
        step(3);
        check("fill3_count", 32'(Count), 32'd3);
        check("fill3_addr", Imem_Addr, 32'h5C);

        // Redirect to a misaligned target with three entries queued.
        Redirect        = 1'b1;
        Redirect_Target = 32'h0000_0103;
        expect_from(32'h100);
        #1;
        check("redir_cycle_valid", 32'(Out_Valid), 32'd0);
        step(1);
        Redirect  = 1'b0;
        Out_Ready = 1'b1;
        #1;
        check("redir2_count", 32'(Count), 32'd0);
        check("redir2_valid", 32'(Out_Valid), 32'd0);
        check("redir2_addr", Imem_Addr, 32'h100);
        step(1);
        check("redir2_fill_valid", 32'(Out_Valid), 32'd1);
        step(3);

        // Back-to-back redirects: only the second target may appear.
        Redirect        = 1'b1;
        Redirect_Target = 32'h0000_0200;
        expect_from(32'h300);
        step(1);
        Redirect_Target = 32'h0000_0300;
        step(1);
        Redirect = 1'b0;
        check("b2b_count", 32'(Count), 32'd0);
        check("b2b_addr", Imem_Addr, 32'h300);
        step(5);

`ifdef STAGE_IF_PERF_EN
        check("perf_flush_total", Perf_Flush, 32'd4);
        check("perf_stall_total", Perf_Stall, 32'd8);
`endif
        check("total_pops", 32'(pops), 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
